bit_count_engine: RTL and testbench

- Multi-cycle, parametrised bit-statistics engine; successor to the single-byte zero counter.
- Accepts a DATA_W-bit word over a valid/ready handshake and scans it CHUNK_W bits per cycle.
- Returns one of four counts: zeros, ones, leading zeros or trailing zeros.
- Sits between a producer stream and a consumer stream in the detection datapath; both sides may stall.

---
 rtl/bit_count_pkg.sv | 15 +
 rtl/bit_count_engine_chunk_counter.sv | 47 ++++
 rtl/bit_count_engine.sv | 141 ++++++++++++++
 tb/tb_bit_count_engine.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bit_count_pkg.sv
// Shared constants for the bit-statistics engine: count modes and FSM state encodings.
package bit_count_pkg;

  localparam logic [1:0] MODE_ZEROS = 2'b00;
  localparam logic [1:0] MODE_ONES  = 2'b01;
  localparam logic [1:0] MODE_LZ    = 2'b10;
  localparam logic [1:0] MODE_TZ    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/bit_count_engine_chunk_counter.sv
// Combinational per-chunk statistic: zeros, ones, leading or trailing zeros of one chunk,
// plus a flag telling whether the chunk holds any set bit.
module chunk_counter
  import bit_count_pkg::*;
#(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0]           chunk,
  input  logic [1:0]                   mode,
  output logic [$clog2(CHUNK_W+1)-1:0] cnt,
  output logic                         has_one
);

  localparam int CW = $clog2(CHUNK_W + 1);

  logic [CW-1:0] ones;
  logic [CW-1:0] lz;
  logic [CW-1:0] tz;

  always_comb begin
    ones = '0;
    lz   = CW'(CHUNK_W);
    tz   = CW'(CHUNK_W);
    // Ascending scan: the highest set bit is the last to overwrite lz.
    for (int i = 0; i < CHUNK_W; i++) begin
      ones = ones + CW'(chunk[i]);
      if (chunk[i]) lz = CW'(CHUNK_W - 1 - i);
    end
    for (int i = CHUNK_W - 1; i >= 0; i--) begin
      if (chunk[i]) tz = CW'(i);
    end
  end

  always_comb begin
    cnt = '0;
    unique case (mode)
      MODE_ZEROS: cnt = CW'(CHUNK_W) - ones;
      MODE_ONES:  cnt = ones;
      MODE_LZ:    cnt = lz;
      MODE_TZ:    cnt = tz;
      default:    cnt = '0;
    endcase
  end

  assign has_one = |chunk;

endmodule

// File: rtl/bit_count_engine.sv
// Multi-cycle bit-statistics engine: takes a DATA_W word over valid/ready, scans it
// CHUNK_W bits per cycle and returns a zero/one/leading-zero/trailing-zero count.
//
//   state   | meaning
//   IDLE    | in_ready=1, waiting for a word
//   BUSY    | scanning chunk idx 0..NCHUNK-1, in_ready=0
//   DONE    | first cycle loads the output register, then out_valid=1 until out_ready
module bit_count_engine
  import bit_count_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [1:0]                  in_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DATA_W+1)-1:0] out_count,
  output logic [1:0]                  out_mode
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int CCW    = $clog2(CHUNK_W + 1);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((DATA_W % CHUNK_W) != 0 || CHUNK_W > DATA_W) begin : g_cfg_err
    $error("bit_count_engine: DATA_W must be a positive multiple of CHUNK_W");
  end

  state_t             state_q;
  state_t             state_d;
  logic [DATA_W-1:0]  data_q;
  logic [1:0]         mode_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   acc_q;
  logic               found_q;
  logic               out_valid_q;

  logic [CHUNK_W-1:0] chunks [NCHUNK];
  logic [IDX_W-1:0]   sel;
  logic [CCW-1:0]     chunk_cnt;
  logic               chunk_has_one;
  logic [CNT_W-1:0]   acc_step;
  logic               found_step;
  logic               last;

  for (genvar g = 0; g < NCHUNK; g++) begin : g_chunks
    assign chunks[g] = data_q[g*CHUNK_W +: CHUNK_W];
  end

  // Leading-zero scans walk from the MSB chunk downward.
  assign sel  = (mode_q == MODE_LZ) ? (LAST_IDX - idx_q) : idx_q;
  assign last = (idx_q == LAST_IDX);

  chunk_counter #(.CHUNK_W(CHUNK_W)) u_chunk_counter (
    .chunk   (chunks[sel]),
    .mode    (mode_q),
    .cnt     (chunk_cnt),
    .has_one (chunk_has_one)
  );

  always_comb begin
    acc_step   = acc_q;
    found_step = found_q;
    if (mode_q == MODE_ZEROS || mode_q == MODE_ONES) begin
      acc_step = acc_q + CNT_W'(chunk_cnt);
    end else if (!found_q) begin
      acc_step   = acc_q + CNT_W'(chunk_cnt);
      found_step = chunk_has_one;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_BUSY;
      end
      ST_BUSY: if (last) state_d = ST_DONE;
      ST_DONE: if (out_valid_q && out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q      <= '0;
      mode_q      <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      found_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_count   <= '0;
      out_mode    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            mode_q  <= in_mode;
            idx_q   <= '0;
            acc_q   <= '0;
            found_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          acc_q   <= acc_step;
          found_q <= found_step;
          idx_q   <= last ? '0 : idx_q + 1'b1;
        end
        ST_DONE: begin
          // Result is published once and then held until the consumer takes it.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_count   <= acc_q;
            out_mode    <= mode_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bit_count_engine.sv
// Bench for bit_count_engine: four instances (CHUNK_W 8, 1, 4, 32) share stimulus and are
// checked against a plain arithmetic reference model.
module tb_bit_count_engine;
  import bit_count_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        out_ready;

  logic        ir [4];
  logic        ov [4];
  logic [5:0]  cnt [4];
  logic [1:0]  om [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bit_count_engine #(.DATA_W(32), .CHUNK_W(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov[0]), .out_ready(out_ready), .out_count(cnt[0]),
    .out_mode(om[0]));
  bit_count_engine #(.DATA_W(32), .CHUNK_W(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov[1]), .out_ready(out_ready), .out_count(cnt[1]),
    .out_mode(om[1]));
  bit_count_engine #(.DATA_W(32), .CHUNK_W(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov[2]), .out_ready(out_ready), .out_count(cnt[2]),
    .out_mode(om[2]));
  bit_count_engine #(.DATA_W(32), .CHUNK_W(32)) u_c32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov[3]), .out_ready(out_ready), .out_count(cnt[3]),
    .out_mode(om[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(input logic [31:0] d, input logic [1:0] m);
    int n = 0;
    case (m)
      2'b00: n = 32 - $countones(d);
      2'b01: n = $countones(d);
      2'b10: for (int i = 31; i >= 0; i--) begin if (d[i]) break; n++; end
      default: for (int i = 0; i < 32; i++) begin if (d[i]) break; n++; end
    endcase
    return n;
  endfunction

  // One word through all four instances; out_ready held high, latency = NCHUNK+1 edges.
  task automatic run_word(input logic [31:0] d, input logic [1:0] m);
    int   exp_lat [4] = '{5, 33, 9, 2};
    int   lat [4]     = '{0, 0, 0, 0};
    logic [5:0] got_c [4];
    logic [1:0] got_m [4];
    int   exp_c;
    @(negedge clk);
    for (int i = 0; i < 4; i++) check($sformatf("ready_i%0d", i), ir[i], 1'b1);
    in_data = d; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_mode  = 2'($urandom_range(3));
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (ov[i] && lat[i] == 0) begin
          lat[i] = c; got_c[i] = cnt[i]; got_m[i] = om[i];
        end
      end
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
    end
    exp_c = ref_count(d, m);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lat_i%0d_d%08h_m%0d", i, d, m), lat[i], exp_lat[i]);
      check($sformatf("cnt_i%0d_d%08h_m%0d", i, d, m), got_c[i], exp_c);
      check($sformatf("mode_i%0d_d%08h_m%0d", i, d, m), got_m[i], m);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_c;
    int c;
    logic [31:0] w;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", ir[0], 1'b1);
    check("rst_out_valid", ov[0], 1'b0);
    check("rst_out_count", cnt[0], 6'd0);
    check("rst_out_mode", om[0], 2'd0);
    rst_n = 1'b1;

    run_word(32'h0000_0000, MODE_ZEROS);
    run_word(32'h0000_0000, MODE_LZ);
    run_word(32'h0000_0000, MODE_TZ);
    run_word(32'hFFFF_FFFF, MODE_ZEROS);
    run_word(32'hFFFF_FFFF, MODE_ONES);
    run_word(32'hFFFF_FFFF, MODE_LZ);
    run_word(32'hFFFF_FFFF, MODE_TZ);
    run_word(32'h0001_0000, MODE_LZ);
    run_word(32'h0001_0000, MODE_TZ);
    run_word(32'h0001_0000, MODE_ONES);
    run_word(32'h8000_0001, MODE_LZ);
    run_word(32'h8000_0001, MODE_TZ);
    run_word(32'hA5A5_A5A5, MODE_ZEROS);

    // Backpressure: stall in DONE, spurious in_valid pulses must be ignored.
    @(negedge clk);
    in_data = 32'h1234_5678; in_mode = MODE_ONES; in_valid = 1'b1; out_ready = 1'b0;
    exp_c = ref_count(32'h1234_5678, MODE_ONES);
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    while (!ov[0] && c < 20) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(1));
      in_data  = $urandom;
      in_mode  = 2'($urandom_range(3));
      c++;
    end
    check("bp_reach_done", ov[0], 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", ov[0], 1'b1);
      check("bp_out_count", cnt[0], exp_c);
      check("bp_out_mode", om[0], MODE_ONES);
      check("bp_in_ready", ir[0], 1'b0);
      in_valid = 1'($urandom_range(1));
      in_data  = $urandom;
      in_mode  = 2'($urandom_range(3));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", ov[0], 1'b0);
    check("bp_release_ready", ir[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_no_dup", ov[0], 1'b0);
    end
    c = 0;
    while (!(ir[0] && ir[1] && ir[2] && ir[3]) && c < 60) begin
      @(negedge clk);
      c++;
    end
    check("bp_all_idle", ir[0] && ir[1] && ir[2] && ir[3], 1'b1);

    // Reset while main instance is scanning chunk index 2.
    @(negedge clk);
    in_data = 32'hDEAD_BEEF; in_mode = MODE_ZEROS; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstbusy_in_ready", ir[0], 1'b1);
    check("rstbusy_out_valid", ov[0], 1'b0);
    check("rstbusy_out_count", cnt[0], 6'd0);
    rst_n = 1'b1;
    run_word(32'h0F0F_00F0, MODE_TZ);

    for (int n = 0; n < 30; n++) begin
      w = $urandom;
      case ($urandom_range(3))
        0: w = w & 32'h0000_FFFF;
        1: w = w & 32'hFF00_0000;
        default: ;
      endcase
      run_word(w, 2'($urandom_range(3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
